// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock,
// with the carry held in a register between chunks to keep the critical path short.
module chunked_adder_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N      = WIDTH / CHUNK;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One chunk of the ripple: {carry_out, sum} of x + y + ci.
    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Carry into the MSB is recovered as x^y^s of the MSB bit, so no extra tap is needed.
    function automatic logic msb_ovf(input logic x_msb, input logic y_msb,
                                     input logic s_msb, input logic c_out);
        msb_ovf = (x_msb ^ y_msb ^ s_msb) ^ c_out;
    endfunction

    state_t             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic               carry_q,  carry_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [BASE_W-1:0]  base_s;
    logic [CHUNK:0]     chunk_s;

    // Next-state, operand capture and per-chunk arithmetic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        base_s  = BASE_W'(idx_q) * BASE_W'(CHUNK);
        chunk_s = chunk_add(a_q[base_s +: CHUNK], b_q[base_s +: CHUNK], carry_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                shadow_d[base_s +: CHUNK] = chunk_s[CHUNK-1:0];
                carry_d                   = chunk_s[CHUNK];
                if (idx_q == LAST_IDX) begin
                    sum_d   = shadow_d;
                    cout_d  = chunk_s[CHUNK];
                    ovf_d   = msb_ovf(a_q[WIDTH-1], b_q[WIDTH-1],
                                      chunk_s[CHUNK-1], chunk_s[CHUNK]);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over start and aborts any run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= {IDX_W{1'b0}};
            carry_q  <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            shadow_q <= {WIDTH{1'b0}};
            sum_q    <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Scoreboard bench: CHUNK=4 instance gets directed vectors, CHUNK=1 and CHUNK=16
// instances get random operand sweeps checked against a behavioural model.
module tb_chunked_adder_seq;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [31:0] acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_s [3];
    logic        sub_s   [3];
    logic        cin_s   [3];
    logic [15:0] a_s     [3];
    logic [15:0] b_s     [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic        cout_o  [3];
    logic        ovf_o   [3];
    logic [15:0] sum_o   [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int CK = (k == 0) ? 4 : ((k == 1) ? 1 : 16);
        chunked_adder_seq #(.WIDTH(16), .CHUNK(CK)) u_dut (
            .clk(clk), .rst(rst), .start(start_s[k]), .sub(sub_s[k]),
            .a(a_s[k]), .b(b_s[k]), .cin(cin_s[k]),
            .busy(busy_o[k]), .done(done_o[k]), .sum(sum_o[k]),
            .cout(cout_o[k]), .ovf(ovf_o[k])
        );
    end

    exp_t exp_q [3][$];
    int   cyc = 0;
    logic rst_prev = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   to_cnt  [3] = '{0, 0, 0};
    int   to_seen [3] = '{0, 0, 0};
    bit   armed = 1'b0;
    logic [17:0] held [3];
    int   busy_run  [3];
    bit   done_prev [3];
    exp_t e;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    function automatic int lat(input int k);
        case (k)
            0:       lat = 4;
            1:       lat = 16;
            default: lat = 1;
        endcase
    endfunction

    task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard whenever done is seen.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_prev === 1'b1) begin
                armed = 1'b1;
                check("reset_outs", k, {busy_o[k], done_o[k], sum_o[k], cout_o[k], ovf_o[k]}, 64'd0);
                held[k]      = 18'd0;
                busy_run[k]  = 0;
                done_prev[k] = 1'b0;
                exp_q[k].delete();
            end else if (armed) begin
                if (busy_o[k] === 1'b1) busy_run[k]++;
                if (done_o[k] === 1'b1) begin
                    check("done_width", k, done_prev[k], 64'd0);
                    check("pending_on_done", k, exp_q[k].size() != 0, 64'd1);
                    if (exp_q[k].size() != 0) begin
                        e = exp_q[k].pop_front();
                        check("result", k, {sum_o[k], cout_o[k], ovf_o[k]}, {e.sum, e.cout, e.ovf});
                        check("latency", k, cyc - int'(e.acc), lat(k));
                        check("busy_cycles", k, busy_run[k], lat(k));
                        held[k] = {e.sum, e.cout, e.ovf};
                    end
                    busy_run[k] = 0;
                end else begin
                    check("hold", k, {sum_o[k], cout_o[k], ovf_o[k]}, held[k]);
                end
                done_prev[k] = done_o[k];
            end
            if (to_cnt[k] != to_seen[k]) begin
                check("drain_timeout", k, to_cnt[k] - to_seen[k], 64'd0);
                to_seen[k] = to_cnt[k];
            end
        end
    end

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb);
        exp_t r;
        logic [16:0] t;
        r = '0;
        if (sb) begin
            r.sum  = x - y;
            r.cout = (x >= y);
            r.ovf  = (x[15] != y[15]) && (r.sum[15] != x[15]);
        end else begin
            t      = {1'b0, x} + {1'b0, y} + {16'd0, ci};
            r.sum  = t[15:0];
            r.cout = t[16];
            r.ovf  = (x[15] == y[15]) && (r.sum[15] != x[15]);
        end
        return r;
    endfunction

    task automatic issue(input int k, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb,
                         input logic [15:0] es, input logic ec, input logic eo);
        exp_t x;
        a_s[k] = av; b_s[k] = bv; cin_s[k] = ci; sub_s[k] = sb; start_s[k] = 1'b1;
        @(posedge clk); #1;
        x.sum = es; x.cout = ec; x.ovf = eo; x.acc = 32'(cyc);
        exp_q[k].push_back(x);
        start_s[k] = 1'b0;
        a_s[k]   = 16'($urandom);
        b_s[k]   = 16'($urandom);
        cin_s[k] = 1'($urandom);
        sub_s[k] = 1'($urandom);
    endtask

    task automatic drain(input int k);
        int t;
        t = 0;
        while (exp_q[k].size() != 0 && t < 80) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q[k].size() != 0) begin
            to_cnt[k]++;
            exp_q[k].delete();
        end
    endtask

    task automatic sweep(input int k);
        logic [15:0] x, y;
        logic        ci;
        exp_t        m;
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 1000; i++) begin
                x  = 16'($urandom);
                y  = 16'($urandom);
                ci = 1'($urandom);
                m  = model(x, y, ci, 1'(mode));
                issue(k, x, y, ci, 1'(mode), m.sum, m.cout, m.ovf);
                drain(k);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0; sub_s[k] = 1'b0; cin_s[k] = 1'b0;
            a_s[k] = 16'h0000; b_s[k] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed add/subtract vectors with hand-computed results.
        issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0); drain(0);
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); drain(0);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); drain(0);
        issue(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0); drain(0);
        issue(0, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0); drain(0);
        issue(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0); drain(0);
        issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); drain(0);
        issue(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0); drain(0);

        // start pulsed mid-run with other operands must be ignored.
        issue(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_s[0] = 16'hFFFF; b_s[0] = 16'hFFFF; sub_s[0] = 1'b1; start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        drain(0);
        repeat (6) @(posedge clk);
        #1;

        // start held through DONE: back-to-back second operation.
        a_s[0] = 16'h0100; b_s[0] = 16'h0200; cin_s[0] = 1'b0; sub_s[0] = 1'b0; start_s[0] = 1'b1;
        @(posedge clk); #1;
        e.sum = 16'h0300; e.cout = 1'b0; e.ovf = 1'b0; e.acc = 32'(cyc);
        exp_q[0].push_back(e);
        a_s[0] = 16'h1000; b_s[0] = 16'h0001; sub_s[0] = 1'b1;
        t = 0;
        while (done_o[0] !== 1'b1 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 40) to_cnt[0]++;
        @(posedge clk); #1;
        e.sum = 16'h0FFF; e.cout = 1'b1; e.ovf = 1'b0; e.acc = 32'(cyc);
        exp_q[0].push_back(e);
        start_s[0] = 1'b0;
        drain(0);
        repeat (3) @(posedge clk);
        #1;

        // Reset two cycles into a run: outputs cleared, no done pulse afterwards.
        issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        issue(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0); drain(0);

        fork
            sweep(1);
            sweep(2);
        join

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
